// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// The configuration struct is sized for the default pattern width.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

  localparam logic [11:0] SEQ_LEGACY_PATTERN = 12'hEDB;

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pattern;
    logic [MAX_LEN_DEF-1:0] mask;
    logic [LEN_W_DEF-1:0]   len;
    logic                   overlap;
  } seq_cfg_t;

  // Low 'len' bits set; wide enough for the largest supported pattern.
  function automatic logic [31:0] len_mask(input logic [5:0] len);
    logic [31:0] m;
    if (len >= 6'd32) begin
      m = 32'hFFFF_FFFF;
    end else begin
      m = (32'd1 << len) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter with a sticky saturation flag.
// A clear that coincides with an increment leaves the count at one.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic [W-1:0] w_cnt_next;
  logic         w_sat_next;

  // Next-state selection: clear first, then increment or saturate.
  always_comb begin
    w_cnt_next = r_cnt;
    w_sat_next = r_sat;
    if (i_clr) begin
      w_cnt_next = {{(W-1){1'b0}}, i_inc};
      w_sat_next = 1'b0;
    end else if (i_inc) begin
      if (r_cnt == CNT_MAX) begin
        w_sat_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_cnt_next = r_cnt;
      w_sat_next = r_sat;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_sat <= w_sat_next;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector with masked compare,
// fill guard, overlap control and a saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                     MAX_LEN     = 16,
  parameter int                     CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]     RST_PATTERN = 16'h0EDB,
  parameter int                     RST_LEN     = 12,
  localparam int                    LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               x_vld,
  input  logic               x_i,
  input  logic               clr_cnt_i,
  output logic               det_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               cnt_sat_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_sh;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [MAX_LEN-1:0] r_mask;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_det;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_sh_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_lenmask;
  logic               w_match;

  assign w_accept  = en & x_vld & ~cfg_we;
  assign w_sh_next = {r_sh[MAX_LEN-2:0], x_i};
  assign w_lenmask = MAX_LEN'(len_mask(6'(r_len)));

  // Fill advance, length clamp and match evaluation on the post-shift view.
  always_comb begin
    w_fill_next   = r_fill;
    w_len_clamped = cfg_len;
    w_match       = 1'b0;
    if (r_fill >= LEN_MAX) begin
      w_fill_next = LEN_MAX;
    end else begin
      w_fill_next = r_fill + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    if (cfg_len > LEN_MAX) begin
      w_len_clamped = LEN_MAX;
    end else begin
      w_len_clamped = cfg_len;
    end
    if (w_accept && (r_len != {LEN_W{1'b0}}) && (w_fill_next >= r_len)) begin
      w_match = (((w_sh_next ^ r_pattern) & r_mask & w_lenmask) == {MAX_LEN{1'b0}});
    end else begin
      w_match = 1'b0;
    end
  end

  // Configuration, history and match pulse registers; a reload restarts history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh      <= {MAX_LEN{1'b0}};
      r_fill    <= {LEN_W{1'b0}};
      r_pattern <= RST_PATTERN;
      r_mask    <= {MAX_LEN{1'b1}};
      r_len     <= LEN_W'(RST_LEN);
      r_overlap <= 1'b1;
      r_det     <= 1'b0;
    end else begin
      r_det <= w_match;
      if (cfg_we) begin
        r_pattern <= cfg_pattern;
        r_mask    <= cfg_mask;
        r_len     <= w_len_clamped;
        r_overlap <= cfg_overlap;
        r_sh      <= {MAX_LEN{1'b0}};
        r_fill    <= {LEN_W{1'b0}};
      end else if (w_accept) begin
        r_sh <= w_sh_next;
        if (w_match && !r_overlap) begin
          r_fill <= {LEN_W{1'b0}};
        end else begin
          r_fill <= w_fill_next;
        end
      end else begin
        r_sh   <= r_sh;
        r_fill <= r_fill;
      end
    end
  end

  seq_det_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .i_inc (r_det),
    .i_clr (clr_cnt_i),
    .o_cnt (match_cnt_o),
    .o_sat (cnt_sat_o)
  );

  assign det_o = r_det;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog with a 4-bit match counter.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [15:0] cfg_mask;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;
  logic        en;
  logic        x_vld;
  logic        x_i;
  logic        clr_cnt_i;
  logic        det_o;
  logic [3:0]  match_cnt_o;
  logic        cnt_sat_o;

  int n_checks = 0;
  int n_fails  = 0;

  seq_det_prog #(.CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .en          (en),
    .x_vld       (x_vld),
    .x_i         (x_i),
    .clr_cnt_i   (clr_cnt_i),
    .det_o       (det_o),
    .match_cnt_o (match_cnt_o),
    .cnt_sat_o   (cnt_sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic seq_cfg_t mk_cfg(input logic [15:0] p, input logic [15:0] m,
                                      input logic [4:0] l, input logic o);
    seq_cfg_t c;
    c.pattern = p;
    c.mask    = m;
    c.len     = l;
    c.overlap = o;
    return c;
  endfunction

  task automatic send(input logic b, input logic v, input logic e);
    x_i   = b;
    x_vld = v;
    en    = e;
    @(posedge clk);
    #1;
    x_vld = 1'b0;
    en    = 1'b1;
  endtask

  task automatic idle();
    x_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Bits go MSB first; exp_det[i] is the det_o expected after bits[i].
  task automatic send_seq(input string tag, input logic [31:0] bits, input int n,
                          input logic [31:0] exp_det);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b1, 1'b1);
      chk_eq($sformatf("%s[%0d]", tag, n - 1 - i), {31'd0, det_o}, {31'd0, exp_det[i]});
    end
  endtask

  // Drives a valid 1 alongside cfg_we to show the bit is dropped.
  task automatic load_cfg(input seq_cfg_t c);
    cfg_pattern = c.pattern;
    cfg_mask    = c.mask;
    cfg_len     = c.len;
    cfg_overlap = c.overlap;
    cfg_we      = 1'b1;
    clr_cnt_i   = 1'b1;
    x_vld       = 1'b1;
    x_i         = 1'b1;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    clr_cnt_i = 1'b0;
    x_vld     = 1'b0;
    chk_eq("cfg_det", {31'd0, det_o}, 32'd0);
    chk_eq("cfg_cnt", {28'd0, match_cnt_o}, 32'd0);
  endtask

  logic [31:0] edb;
  logic        gap_b   [7];
  logic        gap_v   [7];
  logic        gap_e   [7];
  logic        gap_exp [7];

  initial begin
    edb         = 32'(SEQ_LEGACY_PATTERN);
    reset_n     = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = 16'h0000;
    cfg_mask    = 16'h0000;
    cfg_len     = 5'd0;
    cfg_overlap = 1'b0;
    en          = 1'b1;
    x_vld       = 1'b0;
    x_i         = 1'b0;
    clr_cnt_i   = 1'b0;
    #3;
    chk_eq("rst_det", {31'd0, det_o}, 32'd0);
    chk_eq("rst_cnt", {28'd0, match_cnt_o}, 32'd0);
    chk_eq("rst_sat", {31'd0, cnt_sat_o}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();

    // Legacy pattern straight out of reset.
    send_seq("legacy", edb, 12, 32'h001);
    idle();
    chk_eq("legacy_cnt", {28'd0, match_cnt_o}, 32'd1);

    // Overlap versus non-overlap on 101.
    load_cfg(mk_cfg(16'h0005, 16'h0007, 5'd3, 1'b1));
    send_seq("ovl", 32'b10101, 5, 32'b00101);
    idle();
    chk_eq("ovl_cnt", {28'd0, match_cnt_o}, 32'd2);
    load_cfg(mk_cfg(16'h0005, 16'h0007, 5'd3, 1'b0));
    send_seq("novl", 32'b10101, 5, 32'b00100);
    idle();
    chk_eq("novl_cnt", {28'd0, match_cnt_o}, 32'd1);

    // Don't-care mask on the inner two bits.
    load_cfg(mk_cfg(16'h0009, 16'h0009, 5'd4, 1'b0));
    send_seq("mask", 32'b1111_1001, 8, 32'b0001_0001);
    idle();

    // Invalid and disabled cycles must not disturb history.
    load_cfg(mk_cfg(16'h0005, 16'h0007, 5'd3, 1'b1));
    gap_b   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    gap_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    gap_e   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    gap_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      send(gap_b[i], gap_v[i], gap_e[i]);
      chk_eq($sformatf("gap[%0d]", i), {31'd0, det_o}, {31'd0, gap_exp[i]});
    end
    idle();

    // Fill guard: all-zero history must not match before len bits.
    load_cfg(mk_cfg(16'h0000, 16'hFFFF, 5'd4, 1'b1));
    send_seq("fill", 32'b0000, 4, 32'b0001);
    idle();

    // Zero length never matches.
    load_cfg(mk_cfg(16'h0000, 16'hFFFF, 5'd0, 1'b1));
    send_seq("len0", 32'b0000, 4, 32'b0000);
    idle();

    // Oversized length clamps to 16.
    load_cfg(mk_cfg(16'hFFFF, 16'hFFFF, 5'd31, 1'b1));
    send_seq("clamp", 32'h0000_FFFF, 16, 32'h0000_0001);
    idle();

    // Counter saturation, then clear coincident with a match pulse.
    load_cfg(mk_cfg(16'h0001, 16'h0001, 5'd1, 1'b1));
    send_seq("sat", 32'h0001_FFFF, 17, 32'h0001_FFFF);
    idle();
    chk_eq("sat_cnt", {28'd0, match_cnt_o}, 32'd15);
    chk_eq("sat_flag", {31'd0, cnt_sat_o}, 32'd1);
    send(1'b1, 1'b1, 1'b1);
    chk_eq("clr_det", {31'd0, det_o}, 32'd1);
    clr_cnt_i = 1'b1;
    idle();
    clr_cnt_i = 1'b0;
    chk_eq("clr_cnt", {28'd0, match_cnt_o}, 32'd1);
    chk_eq("clr_sat", {31'd0, cnt_sat_o}, 32'd0);

    // Reload mid-pattern discards the partial history.
    load_cfg(mk_cfg({4'h0, SEQ_LEGACY_PATTERN}, 16'hFFFF, 5'd12, 1'b1));
    send_seq("pre", edb >> 1, 11, 32'd0);
    load_cfg(mk_cfg({4'h0, SEQ_LEGACY_PATTERN}, 16'hFFFF, 5'd12, 1'b1));
    send(1'b1, 1'b1, 1'b1);
    chk_eq("reload_det", {31'd0, det_o}, 32'd0);
    send_seq("fresh", edb, 12, 32'h001);
    idle();
    chk_eq("fresh_cnt", {28'd0, match_cnt_o}, 32'd1);

    // Asynchronous reset mid-pattern.
    send_seq("half", edb >> 6, 6, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("arst_cnt", {28'd0, match_cnt_o}, 32'd0);
    chk_eq("arst_det", {31'd0, det_o}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_seq("tail", edb & 32'h3F, 6, 32'd0);
    send_seq("post", edb, 12, 32'h001);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("arst_pulse", {31'd0, det_o}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Parametrised, runtime-programmable serial sequence detector; the next generation of the fixed 12-bit detector.
- Adds:
  - programmable pattern, length and don't-care mask;
  - valid-qualified input and an enable;
  - overlapping / non-overlapping match modes;
  - a fill guard, so no match is reported before enough bits have arrived;
  - a saturating match counter.
- Sits between a serial bit source and control/status logic.
- Reset defaults give the same detection as the legacy 12-bit block (pattern 0xEDB, length 12).

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (2..32).
- CNT_W, 8, match counter width.
- RST_PATTERN, 16'h0EDB, pattern loaded at reset (MAX_LEN bits wide).
- RST_LEN, 12, pattern length loaded at reset.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  load configuration from the cfg_* inputs this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = most recent bit.
- cfg_mask  in  MAX_LEN  1 = compare this bit, 0 = don't care.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- en  in  1  detector enable.
- x_vld  in  1  x_i is valid this cycle.
- x_i  in  1  serial data bit.
- clr_cnt_i  in  1  synchronous clear of match_cnt_o and cnt_sat_o.
- det_o  out  1  one-cycle match pulse (registered).
- match_cnt_o  out  CNT_W  number of matches, saturating.
- cnt_sat_o  out  1  sticky flag: counter has saturated.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - shift register sh=0, fill=0;
  - pattern=RST_PATTERN, mask=all ones, len=RST_LEN, overlap=1;
  - det_o=0, match_cnt_o=0, cnt_sat_o=0.
  - Release is synchronous to clk. Reset mid-stream discards all partial history.
- Configuration:
  - On cfg_we=1, latch pattern, mask, len and overlap, clear sh and fill, and force det_o=0 on the next cycle.
  - cfg_we has priority over a simultaneous x_vld; that input bit is dropped.
  - cfg_len>MAX_LEN is clamped to MAX_LEN.
  - cfg_len=0 disables matching; bits still shift.
- Sampling (accepted bit):
  - A bit is accepted on an edge where en=1, x_vld=1 and cfg_we=0.
  - sh <= {sh[MAX_LEN-2:0], x_i}.
  - fill <= min(fill+1, MAX_LEN).
  - When en=0 or x_vld=0, all state holds and det_o=0 next cycle.
- Match condition (evaluated on next-state values of an accepted bit):
  - len != 0;
  - fill_next >= len;
  - ((sh_next ^ pattern) & mask & lenmask) == 0, where lenmask has the low len bits set.
- det_o timing:
  - Registered; high for exactly the one cycle after the edge that sampled the completing bit. Latency = 1 cycle, matching the legacy block.
  - Back-to-back accepted bits can produce det_o on consecutive cycles (overlap mode).
- Non-overlap mode (overlap=0):
  - On a match, fill <= 0. The next match needs len fresh bits.
  - sh still shifts normally.
- Counter:
  - On det_o assertion, match_cnt_o increments, saturating at 2^CNT_W-1.
  - cnt_sat_o sets when an increment is requested at the maximum, and is sticky.
  - clr_cnt_i clears both. If a clear coincides with an increment, the result is match_cnt_o=1 and cnt_sat_o=0.
- Width rules: LEN_W-bit comparisons are unsigned; fill is LEN_W bits, saturating.

Decomposition:
- Package seq_det_pkg:
  - typedef seq_cfg_t as a struct {pattern, mask, len, overlap}, parametrised through the package-level MAX_LEN_DEF;
  - function len_mask(len) returning lenmask;
  - constant SEQ_LEGACY_PATTERN = 12'hEDB.
- One sub-module, seq_det_sat_cnt: generic saturating counter with inc, clr, sticky saturation flag, and parameter W.
- The shift/fill/match logic stays in the top module.

Test Plan:
- Defaults after reset; feed 1,1,1,0,1,1,0,1,1,0,1,1 (MSB first) with x_vld=1 -> det_o=1 for one cycle after the 12th bit; match_cnt_o=1; no det_o on the earlier 11 bits.
- cfg pattern=3'b101, mask=3'b111, len=3, overlap=1; feed 1,0,1,0,1 -> det_o after bits 3 and 5; count=2. Same stream with overlap=0 -> det_o after bit 3 only; count=1.
- Mask: pattern=4'b1001, mask=4'b1001, len=4; feed 1,1,1,1 and then 1,0,0,1 -> det_o after each of the two 4-bit groups.
- Gaps: x_vld toggled 1,0,1,0 with en=0 for two cycles mid-pattern -> no det_o and no fill advance while invalid or disabled; match still fires on the completing valid bit.
- CNT_W=4; generate 17 matches -> match_cnt_o=15, cnt_sat_o=1. Then clr_cnt_i coincident with a det_o -> count=1, sat=0.
- cfg_we after 11 bits of the default pattern, reloading the same config -> 12th bit gives no det_o; a fresh 12-bit pattern is required. Assert reset_n low mid-pattern -> all outputs 0 immediately and history is lost.
